// File: rtl/multiplier_shift_add_unsigned.sv
// Sequential unsigned shift-add multiply-accumulate: PRODUCT_OUT = MULTIPLICAND_IN*MULTIPLIER_IN + ADDEND_IN.
// Optional macro MUL_REMAINDER_CHECK_EN enables the remainder-legality error flag.
module multiplier_shift_add_unsigned #(
  parameter int MUL_A_BITS = 8,
  parameter int MUL_B_BITS = 8
) (
  input  logic                             CLK,
  input  logic                             ARST,
  input  logic                             CE,
  input  logic [MUL_A_BITS-1:0]            MULTIPLICAND_IN,
  input  logic [MUL_B_BITS-1:0]            MULTIPLIER_IN,
  input  logic [MUL_B_BITS-1:0]            ADDEND_IN,
  output logic [MUL_A_BITS+MUL_B_BITS-1:0] PRODUCT_OUT,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [1:0]                       state_o
);

  localparam int W  = MUL_A_BITS + MUL_B_BITS;
  localparam int CW = $clog2(MUL_B_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(MUL_B_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Handshake: start is accepted on a CE edge only in IDLE or DONE; busy is high
  // for exactly MUL_B_BITS CE edges; done is a level held until the next accept.
  state_t                state_q, state_d;
  logic [W-1:0]          mcand_q, mcand_d;
  logic [MUL_B_BITS-1:0] mplier_q, mplier_d;
  logic [W-1:0]          acc_q, acc_d;
  logic [CW-1:0]         count_q, count_d;
  logic [W-1:0]          product_q, product_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [W-1:0]          add_term;
  logic [W-1:0]          acc_step;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = done_q;
    add_term  = mplier_q[0] ? (mcand_q << count_q) : '0;
    acc_step  = acc_q + add_term;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mcand_d  = {{MUL_B_BITS{1'b0}}, MULTIPLICAND_IN};
          mplier_d = MULTIPLIER_IN;
          acc_d    = {{MUL_A_BITS{1'b0}}, ADDEND_IN};
          count_d  = '0;
          done_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_d    = acc_step;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        // Final iteration publishes the accumulator including this step's add.
        if (count_q == LAST) begin
          product_d = acc_step;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (CE) begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef MUL_REMAINDER_CHECK_EN
  logic error_q;

  // A legal division remainder must be strictly below a nonzero divisor.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      error_q <= 1'b0;
    end else if (CE && start && (state_q != S_RUN)) begin
      error_q <= (MULTIPLIER_IN == '0) || (ADDEND_IN >= MULTIPLIER_IN);
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign PRODUCT_OUT = product_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_multiplier_shift_add_unsigned.sv
// Bench for multiplier_shift_add_unsigned: vector table, hand sequences, random and round-trip ops.
module tb_multiplier_shift_add_unsigned;

  localparam int A = 8;
  localparam int B = 8;

  logic         CLK = 1'b0;
  logic         ARST;
  logic         CE;
  logic [A-1:0] MULTIPLICAND_IN;
  logic [B-1:0] MULTIPLIER_IN;
  logic [B-1:0] ADDEND_IN;
  logic [A+B-1:0] PRODUCT_OUT;
  logic         start;
  logic         busy;
  logic         done;
  logic         error;
  logic [1:0]   state_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[9];

  multiplier_shift_add_unsigned #(.MUL_A_BITS(A), .MUL_B_BITS(B)) dut (
    .CLK(CLK), .ARST(ARST), .CE(CE),
    .MULTIPLICAND_IN(MULTIPLICAND_IN), .MULTIPLIER_IN(MULTIPLIER_IN), .ADDEND_IN(ADDEND_IN),
    .PRODUCT_OUT(PRODUCT_OUT), .start(start), .busy(busy), .done(done), .error(error),
    .state_o(state_o)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model
  function automatic logic [15:0] ref_product(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    int r;
    r = int'(a) * int'(b) + int'(c);
    return r[15:0];
  endfunction

  function automatic logic ref_error(input logic [7:0] b, input logic [7:0] c);
`ifdef MUL_REMAINDER_CHECK_EN
    return (b == 8'd0) || (c >= b);
`else
    return 1'b0;
`endif
  endfunction

  // Driver: one full operation from an accept edge until done (bounded)
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        output logic [15:0] p, output logic e, output int lat, output int busy_cnt);
    @(negedge CLK);
    MULTIPLICAND_IN = a; MULTIPLIER_IN = b; ADDEND_IN = c; start = 1'b1; CE = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      if (busy) busy_cnt++;
    end
    p = PRODUCT_OUT;
    e = error;
  endtask

  logic [15:0] p, exp_q[$];
  logic        e;
  int          lat, bcnt, cyc;
  logic [7:0]  ra, rb, rc, nn, dd;

  initial begin
    vecs[0] = '{a: 8'd13,  b: 8'd10,  c: 8'd7,   p: 16'd137};
    vecs[1] = '{a: 8'd255, b: 8'd255, c: 8'd254, p: 16'd65279};
    vecs[2] = '{a: 8'd0,   b: 8'd0,   c: 8'd0,   p: 16'd0};
    vecs[3] = '{a: 8'd0,   b: 8'd200, c: 8'd199, p: 16'd199};
    vecs[4] = '{a: 8'd200, b: 8'd0,   c: 8'd0,   p: 16'd0};
    vecs[5] = '{a: 8'd37,  b: 8'd6,   c: 8'd5,   p: 16'd227};
    vecs[6] = '{a: 8'd5,   b: 8'd3,   c: 8'd3,   p: 16'd18};
    vecs[7] = '{a: 8'd9,   b: 8'd0,   c: 8'd0,   p: 16'd0};
    vecs[8] = '{a: 8'd9,   b: 8'd4,   c: 8'd3,   p: 16'd39};

    ARST = 1'b1; CE = 1'b0; start = 1'b0;
    MULTIPLICAND_IN = '0; MULTIPLIER_IN = '0; ADDEND_IN = '0;
    repeat (2) @(negedge CLK);
    check("reset_product", 32'(PRODUCT_OUT), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    ARST = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, p, e, lat, bcnt);
      check($sformatf("vec%0d_product", i), 32'(p), 32'(vecs[i].p));
      check($sformatf("vec%0d_error", i), 32'(e), 32'(ref_error(vecs[i].b, vecs[i].c)));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
      check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd8);
    end

    // Asynchronous reset between edges mid-RUN, then recovery
    run_op(8'd13, 8'd10, 8'd7, p, e, lat, bcnt);
    check("pre_reset_product", 32'(p), 32'd137);
    @(negedge CLK);
    MULTIPLICAND_IN = 8'd200; MULTIPLIER_IN = 8'd0; ADDEND_IN = 8'd50; start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    check("midrun_busy", 32'(busy), 32'd1);
    ARST = 1'b1;
    #1;
    check("async_rst_product", 32'(PRODUCT_OUT), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_error", 32'(error), 32'd0);
    #2;
    ARST = 1'b0;
    run_op(8'd13, 8'd10, 8'd7, p, e, lat, bcnt);
    check("post_reset_product", 32'(p), 32'd137);
    check("post_reset_latency", 32'(lat), 32'd8);

    // CE stall of 3 cycles mid-RUN and start pulses ignored during RUN
    @(negedge CLK);
    MULTIPLICAND_IN = 8'd37; MULTIPLIER_IN = 8'd6; ADDEND_IN = 8'd5; start = 1'b1; CE = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    check("run_keeps_old_product", 32'(PRODUCT_OUT), 32'd137);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    CE = 1'b0; start = 1'b1;
    MULTIPLICAND_IN = 8'd255; MULTIPLIER_IN = 8'd255; ADDEND_IN = 8'd255;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_done", 32'(done), 32'd0);
    CE = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    cyc = 7;
    while (!done && cyc < 40) begin
      @(posedge CLK);
      cyc++;
      @(negedge CLK);
    end
    check("stall_latency", 32'(cyc), 32'd11);
    check("stall_product", 32'(PRODUCT_OUT), 32'd227);
    check("stall_busy_end", 32'(busy), 32'd0);
    CE = 1'b0; start = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("ce_low_hold_done", 32'(done), 32'd1);
    check("ce_low_hold_product", 32'(PRODUCT_OUT), 32'd227);
    start = 1'b0; CE = 1'b1;

    // Random operands against the arithmetic model
    for (int i = 0; i < 150; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 8'($urandom_range(0, 255));
      exp_q.push_back(ref_product(ra, rb, rc));
      run_op(ra, rb, rc, p, e, lat, bcnt);
      check("rand_product", 32'(p), 32'(exp_q.pop_front()));
      check("rand_error", 32'(e), 32'(ref_error(rb, rc)));
      check("rand_latency", 32'(lat), 32'd8);
    end

    // Divider round trip: quotient*d + remainder rebuilds n
    for (int d = 1; d < 256; d++) begin
      for (int k = 0; k < 8; k++) begin
        case (k)
          0: nn = 8'd0;
          1: nn = 8'd255;
          2: nn = 8'(d - 1);
          3: nn = 8'(d);
          default: nn = 8'($urandom_range(0, 255));
        endcase
        dd = 8'(d);
        run_op(nn / dd, dd, nn % dd, p, e, lat, bcnt);
        check("roundtrip_product", 32'(p), 32'(nn));
        check("roundtrip_error", 32'(e), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
